// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory port,
// loads the IF/ID register, buffers one word across freezes and drains in-flight fetches on redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [5:0]  if_id_opcode
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_if_id_valid, w_if_id_valid_nxt;
  logic [31:0] r_if_id_pc, w_if_id_pc_nxt;
  logic [31:0] r_if_id_instr, w_if_id_instr_nxt;
  logic [31:0] r_hold_buf, w_hold_buf_nxt;
  logic [31:0] r_redirect_tgt, w_redirect_tgt_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = branch_target & ~32'h0000_0003;

  // In DRAIN the PC is left untouched until the ack, so the address stays stable.
  assign imem_req     = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr    = r_pc;
  assign if_id_valid  = r_if_id_valid;
  assign if_id_pc     = r_if_id_pc;
  assign if_id_instr  = r_if_id_valid ? r_if_id_instr : 32'h0;
  assign if_id_opcode = if_id_instr[31:26];

  always_comb begin
    // NOTE: every target gets its hold value first so no path through the case infers a latch.
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_if_id_valid_nxt  = r_if_id_valid;
    w_if_id_pc_nxt     = r_if_id_pc;
    w_if_id_instr_nxt  = r_if_id_instr;
    w_hold_buf_nxt     = r_hold_buf;
    w_redirect_tgt_nxt = r_redirect_tgt;

    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;

      S_FETCH: begin
        if (branch_taken) begin
          w_if_id_valid_nxt = 1'b0;
          if (imem_ack) begin
            w_pc_nxt = w_target;
          end else begin
            w_redirect_tgt_nxt = w_target;
            w_state_nxt        = S_DRAIN;
          end
        end else if (imem_ack) begin
          if (freeze) begin
            w_hold_buf_nxt = imem_rdata;
            w_state_nxt    = S_HOLD;
          end else begin
            w_if_id_valid_nxt = 1'b1;
            w_if_id_pc_nxt    = w_pc_plus4;
            w_if_id_instr_nxt = imem_rdata;
            w_pc_nxt          = w_pc_plus4;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          w_if_id_valid_nxt = 1'b0;
          w_pc_nxt          = w_target;
          w_state_nxt       = S_FETCH;
        end else if (!freeze) begin
          w_if_id_valid_nxt = 1'b1;
          w_if_id_pc_nxt    = w_pc_plus4;
          w_if_id_instr_nxt = r_hold_buf;
          w_pc_nxt          = w_pc_plus4;
          w_state_nxt       = S_FETCH;
        end
      end

      S_DRAIN: begin
        // A newer redirect always wins, even when it lands on the draining ack.
        if (branch_taken) begin
          w_if_id_valid_nxt  = 1'b0;
          w_redirect_tgt_nxt = w_target;
        end
        if (imem_ack) begin
          w_pc_nxt    = branch_taken ? w_target : r_redirect_tgt;
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_if_id_valid  <= 1'b0;
      r_if_id_pc     <= 32'h0;
      r_if_id_instr  <= 32'h0;
      r_hold_buf     <= 32'h0;
      r_redirect_tgt <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_if_id_valid  <= w_if_id_valid_nxt;
      r_if_id_pc     <= w_if_id_pc_nxt;
      r_if_id_instr  <= w_if_id_instr_nxt;
      r_hold_buf     <= w_hold_buf_nxt;
      r_redirect_tgt <= w_redirect_tgt_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with fixed expectations
// plus a randomized run against a behavioural fetch model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
  );

  always #5 clk = ~clk;

  // Memory contents: a scrambled function of the address so opcodes vary.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive inputs at the falling edge, return at the next falling edge.
  task automatic tick(input logic fz, input logic br, input logic [31:0] tgt, input logic ack);
    freeze        = fz;
    branch_taken  = br;
    branch_target = tgt;
    imem_ack      = ack;
    imem_rdata    = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    freeze       = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
  endtask

  // Reset, release, and step through the IDLE cycle.
  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc got=%h exp=0", if_id_pc); end
    n_checks++; if ({if_id_instr, if_id_opcode} !== 38'h0) begin n_fail++; $display("FAIL reset_instr got=%h/%h exp=0", if_id_instr, if_id_opcode); end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req got=%b@%h exp=1@0", imem_req, imem_addr); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_addr%0d got=%b@%h exp=1@%h", i, imem_req, imem_addr, 4 * i); end
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (i + 1)) || if_id_instr !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL zw_ifid%0d got=%b/%h/%h exp=1/%h/%h", i, if_id_valid, if_id_pc, if_id_instr, 4 * (i + 1), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_latency();
    restart();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL lat_hold%0d got=%b@%h v=%b exp=1@0 v=0", i, imem_req, imem_addr, if_id_valid); end
      tick(1'b0, 1'b0, 32'h0, i == 2);
    end
    n_checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin n_fail++; $display("FAIL lat_first got=%b/%h exp=1/4", if_id_valid, if_id_pc); end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (if_id_pc !== 32'h4 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL lat_nodup got=%h@%h exp=4@4", if_id_pc, imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (if_id_pc !== 32'h8 || if_id_instr !== mem_word(32'h4)) begin n_fail++; $display("FAIL lat_second got=%h/%h exp=8/%h", if_id_pc, if_id_instr, mem_word(32'h4)); end
  endtask

  task automatic test_freeze();
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL frz_addr got=%h exp=8", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 32'h0, i == 0);
      n_checks++; if (imem_req !== 1'b0 || if_id_pc !== 32'h8 || if_id_instr !== mem_word(32'h4)) begin n_fail++; $display("FAIL frz_hold%0d got=%b/%h/%h exp=0/8/%h", i, imem_req, if_id_pc, if_id_instr, mem_word(32'h4)); end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (if_id_instr !== mem_word(32'h8) || if_id_pc !== 32'hC) begin n_fail++; $display("FAIL frz_release got=%h/%h exp=%h/c", if_id_instr, if_id_pc, mem_word(32'h8)); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL frz_next got=%b@%h exp=1@c", imem_req, imem_addr); end
  endtask

  task automatic test_branch_drain();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL br_pre got=%h exp=10", imem_addr); end
    tick(1'b0, 1'b1, 32'h103, 1'b0);
    n_checks++; if (if_id_valid !== 1'b0 || if_id_opcode !== 6'h0 || if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_flush got=%b/%h/%h exp=0/0/0", if_id_valid, if_id_opcode, if_id_instr); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL br_drain got=%b@%h exp=1@10", imem_req, imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_target got=%h v=%b exp=100 v=0", imem_addr, if_id_valid); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (if_id_pc !== 32'h104 || if_id_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL br_first got=%h/%h exp=104/%h", if_id_pc, if_id_instr, mem_word(32'h100)); end
  endtask

  task automatic test_branch_in_hold();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bh_hold got=%b exp=0", imem_req); end
    tick(1'b1, 1'b1, 32'h200, 1'b0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin n_fail++; $display("FAIL bh_redirect got=%b@%h v=%b i=%h exp=1@200 v=0 i=0", imem_req, imem_addr, if_id_valid, if_id_instr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (if_id_pc !== 32'h204 || if_id_instr !== mem_word(32'h200)) begin n_fail++; $display("FAIL bh_first got=%h/%h exp=204/%h", if_id_pc, if_id_instr, mem_word(32'h200)); end
  endtask

  task automatic test_drain_rebranch();
    tick(1'b0, 1'b1, 32'h300, 1'b0);
    tick(1'b0, 1'b1, 32'h400, 1'b0);
    n_checks++; if (imem_addr !== 32'h204) begin n_fail++; $display("FAIL rb_hold got=%h exp=204", imem_addr); end
    tick(1'b0, 1'b1, 32'h500, 1'b1);
    n_checks++; if (imem_addr !== 32'h500 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rb_target got=%h v=%b exp=500 v=0", imem_addr, if_id_valid); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align got=%h exp=fffffffc", imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (imem_addr !== 32'h0 || if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap got=%h/%h/%b/%h exp=0/0/1/%h", imem_addr, if_id_pc, if_id_valid, if_id_instr, mem_word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_mid_request();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== 32'h0) begin n_fail++; $display("FAIL rmid_async got=%b@%h %b/%h/%h exp=0@0 0/0/0", imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_stale got=v%b %b@%h exp=v0 1@0", if_id_valid, imem_req, imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (if_id_pc !== 32'h4 || if_id_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL rmid_restart got=%h/%h exp=4/%h", if_id_pc, if_id_instr, mem_word(32'h0)); end
  endtask

  // Behavioural model: what the fetch unit is doing, described as activity flags.
  task automatic test_random();
    logic        m_started, m_buffered, m_draining, m_v;
    logic [31:0] m_pc, m_buf, m_redir, m_ifpc, m_instr;
    logic        fz, br, ack, exp_req;
    logic [31:0] tgt, rd, exp_instr;
    restart();
    m_started = 1'b1; m_buffered = 1'b0; m_draining = 1'b0; m_v = 1'b0;
    m_pc = 32'h0; m_buf = 32'h0; m_redir = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0;
    for (int c = 0; c < 600; c++) begin
      exp_req   = m_started && !m_buffered;
      exp_instr = m_v ? m_instr : 32'h0;
      n_checks++; if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc)) begin n_fail++; $display("FAIL rnd_req c%0d got=%b@%h exp=%b@%h", c, imem_req, imem_addr, exp_req, m_pc); end
      n_checks++; if (if_id_valid !== m_v || if_id_instr !== exp_instr || if_id_opcode !== exp_instr[31:26]) begin n_fail++; $display("FAIL rnd_ifid c%0d got=%b/%h exp=%b/%h", c, if_id_valid, if_id_instr, m_v, exp_instr); end
      n_checks++; if (m_v && if_id_pc !== m_ifpc) begin n_fail++; $display("FAIL rnd_pc c%0d got=%h exp=%h", c, if_id_pc, m_ifpc); end
      fz  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      tgt = (c % 50 == 7) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7)) : $urandom;
      ack = exp_req && ($urandom_range(0, 2) != 0);
      rd  = ack ? mem_word(m_pc) : $urandom;
      freeze = fz; branch_taken = br; branch_target = tgt; imem_ack = ack; imem_rdata = rd;
      tgt = tgt & ~32'h3;
      @(posedge clk);
      if (m_buffered) begin
        if (br) begin m_buffered = 1'b0; m_v = 1'b0; m_pc = tgt; end
        else if (!fz) begin m_buffered = 1'b0; m_v = 1'b1; m_ifpc = m_pc + 4; m_instr = m_buf; m_pc = m_pc + 4; end
      end else if (m_draining) begin
        if (br) begin m_v = 1'b0; m_redir = tgt; end
        if (ack) begin m_draining = 1'b0; m_pc = m_redir; end
      end else if (br) begin
        m_v = 1'b0;
        if (ack) m_pc = tgt;
        else begin m_draining = 1'b1; m_redir = tgt; end
      end else if (ack) begin
        if (fz) begin m_buffered = 1'b1; m_buf = rd; end
        else begin m_v = 1'b1; m_ifpc = m_pc + 4; m_instr = rd; m_pc = m_pc + 4; end
      end
      @(negedge clk);
      freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_freeze();
    test_branch_drain();
    test_branch_in_hold();
    test_drain_rebranch();
    test_wrap();
    test_reset_mid_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
